// File: rtl/uart_rx_param_if.sv
// Receiver output bundle: received word, qualifiers and busy flag.
// break_det is present only when UART_RX_BREAK_DETECT_EN is defined.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 break_det;
`endif

    modport master (
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
`ifdef UART_RX_BREAK_DETECT_EN
        output break_det,
`endif
        output busy
    );

    modport slave (
        input data_out,
        input data_valid,
        input parity_err,
        input frame_err,
`ifdef UART_RX_BREAK_DETECT_EN
        input break_det,
`endif
        input busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop sync, 3-sample majority, parity/framing errors.
// Optional break detection output enabled by UART_RX_BREAK_DETECT_EN.
module uart_rx_param #(
    parameter int CLK_FREQ  = 125000000,
    parameter int BAUD_RATE = 230400,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    uart_rx_param_if.master bus
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int MID = CPB / 2;
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, DONE
    } state_t;

    state_t               state, state_n;
    logic                 sync1, rx_s, rx_d;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bcnt;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] shift;
    logic                 pbit, ferr_q;
    logic                 fall, tick, wrap, maj, perr;

    always_comb begin
        state_n = state;
        fall    = rx_d & ~rx_s;
        tick    = (cnt == CW'(MID + 1));
        wrap    = (cnt == CW'(CPB - 1));
        maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        // odd mode flags an even total of ones, even mode an odd total
        perr    = (PARITY == 1) ? ~(^shift ^ pbit) : (^shift ^ pbit);
        unique case (state)
            IDLE:  if (fall) state_n = START;
            START: begin
                if (tick && maj) state_n = IDLE;
                else if (wrap)   state_n = DATA;
            end
            DATA: begin
                if (wrap && bcnt == BW'(DATA_BITS - 1))
                    state_n = (PARITY != 0) ? PAR : STOP;
            end
            PAR:   if (wrap) state_n = STOP;
            STOP:  if (tick && bcnt == BW'(STOP_BITS - 1)) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sync1          <= 1'b1;
            rx_s           <= 1'b1;
            rx_d           <= 1'b1;
            cnt            <= '0;
            bcnt           <= '0;
            s0             <= 1'b1;
            s1             <= 1'b1;
            shift          <= '0;
            pbit           <= 1'b0;
            ferr_q         <= 1'b0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            bus.break_det  <= 1'b0;
`endif
        end else begin
            sync1          <= rx;
            rx_s           <= sync1;
            rx_d           <= rx_s;
            state          <= state_n;
            bus.busy       <= (state_n != IDLE);
            bus.data_valid <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            bus.break_det  <= 1'b0;
`endif
            if (state_n != state || state == IDLE || wrap) cnt <= '0;
            else cnt <= cnt + 1'b1;
            if (state_n != state) bcnt <= '0;
            else if (wrap) bcnt <= bcnt + 1'b1;
            if (cnt == CW'(MID - 1)) s0 <= rx_s;
            if (cnt == CW'(MID))     s1 <= rx_s;
            if (state == IDLE && fall) begin
                pbit   <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (tick) begin
                if (state == DATA) shift <= {maj, shift[DATA_BITS-1:1]};
                if (state == PAR)  pbit  <= maj;
                if (state == STOP && !maj) ferr_q <= 1'b1;
            end
            // outputs are loaded as the last stop bit commits, so they show during DONE
            if (state == STOP && state_n == DONE) begin
                bus.data_out   <= shift;
                bus.data_valid <= 1'b1;
                bus.parity_err <= (PARITY != 0) && perr;
                bus.frame_err  <= ferr_q | ~maj;
`ifdef UART_RX_BREAK_DETECT_EN
                bus.break_det  <= (shift == '0) && !pbit && (ferr_q | ~maj);
`endif
            end
        end
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver in the UART/ALU datapath. Adds:
- configurable data width, parity and stop-bit count
- input synchroniser and 3-sample majority vote
- parity and framing error reporting
- busy indication

Sits between the board RX pin and the command parser. Delivers one word per frame as a single-cycle valid pulse.

Parameters:
- CLK_FREQ, 125000000, system clock frequency in Hz.
- BAUD_RATE, 230400, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), must be >= 8.
- DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_BITS  last received word; held until the next completed frame.
- data_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  qualified by data_valid; 1 = parity mismatch. Always 0 when PARITY=0.
- frame_err  out  1  qualified by data_valid; 1 = any stop bit sampled low.
- busy  out  1  high from start-edge detection until return to IDLE.

Behaviour:
- Single clock; reset is synchronous and active-high (rst sampled on rising edge of clk).
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, both synchroniser flops=1, counters=0.
- Reset mid-frame aborts the frame. No data_valid is produced for the aborted frame.
- rx passes through a 2-flop synchroniser; rx_s is the second flop.
- Bit decision is a majority of rx_s sampled at counts CLKS_PER_BIT/2-1, CLKS_PER_BIT/2 and CLKS_PER_BIT/2+1 of each bit period. The bit is committed at count CLKS_PER_BIT/2+1.
- States:
  - IDLE -> START on a falling edge of rx_s (previous 1, current 0). A line held low never re-arms. busy goes high on the same edge.
  - START: majority of start bit. 0 -> DATA. 1 -> IDLE (glitch rejected, no outputs, busy low).
  - DATA: DATA_BITS bits, each decided one bit period after the previous one, shifted in LSB first. -> PARITY if PARITY!=0, else STOP.
  - PARITY: one bit. Mismatch vs odd/even parity of the data sets an internal flag. -> STOP.
  - STOP: STOP_BITS bits. Any bit decided 0 sets an internal framing flag. After the final stop bit -> DONE.
  - DONE: one cycle. data_out<=shift register, data_valid=1, parity_err/frame_err = internal flags. -> IDLE with busy=0.
- Error outputs equal 0 whenever data_valid=0.
- Frames with errors still update data_out and pulse data_valid.
- Latency from rx falling edge to data_valid: 2 sync cycles + (1 + DATA_BITS + P + STOP_BITS - 1)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 2 cycles, where P = 1 if PARITY!=0. Bench tolerance is ±2 cycles.
- A falling edge while not in IDLE is ignored. Back-to-back frames are accepted because DONE is reached mid-stop-bit.
- bit counter and clk counter widths cover DATA_BITS and CLKS_PER_BIT. No overflow or wrap within a frame.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined: adds output port break_det (1 bit, reset 0). It pulses for one cycle together with data_valid when the frame has all data bits 0, the parity bit (if present) 0, and a frame error. In that cycle data_out=0 and frame_err=1 as usual.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
All tests use CLK_FREQ=1000000, BAUD_RATE=100000 (CLKS_PER_BIT=10).
1. 8N1, send 0xA5 -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low the cycle after DONE.
2. PARITY=2, DATA_BITS=8: send 0x07 with parity bit 1 -> parity_err=0. Then 0x07 with parity bit 0 -> parity_err=1, data_out=0x07.
3. 8N1: 0x3C with stop bit driven 0 -> data_valid=1, frame_err=1, data_out=0x3C. Hold line high, then send 0x55 -> data_out=0x55, frame_err=0.
4. Low glitch of 3 clk on idle line -> no data_valid, busy returns 0 within CLKS_PER_BIT cycles.
5. Invert rx for 1 clk at the centre of data bit 3 of 0xF0 -> majority vote keeps data_out=0xF0.
6. Assert rst during data bit 4 -> all outputs 0 next cycle. Then 0x81 with DATA_BITS=9, STOP_BITS=2 -> data_out=0x081, no errors. With UART_RX_BREAK_DETECT_EN, an all-zero frame -> break_det=1, frame_err=1.
